// File: rtl/bsg_axil_to_mcl_pkg.sv
// Shared AXI-Lite to MCL address map, response codes and write-path types.
package bsg_axil_to_mcl_pkg;

  localparam int axil_base_addr_width_gp = 12;
  localparam int axil_slot_idx_width_gp  = 4;
  localparam logic [31:0] axil_m_slot_addr_gp = 32'h0000_2000;

  // Offset of the transmit data register inside a FIFO slot
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_tdr_gp = 12'h010;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;
  localparam logic [1:0] axil_resp_decerr_gp = 2'b11;

  typedef enum logic [1:0] {
    E_WR_IDLE,
    E_WR_DATA,
    E_WR_PUSH,
    E_WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    E_TGT_FIFO,
    E_TGT_REG,
    E_TGT_ERR
  } wr_tgt_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_decode_with_v.sv
// One-hot decoder: onehot_o[sel_i] = v_i, every other bit 0.
module bsg_decode_with_v
  import bsg_axil_to_mcl_pkg::*;
#(
  parameter int num_out_p = 2
) (
  input  logic [safe_clog2(num_out_p)-1:0] sel_i,
  input  logic                             v_i,
  output logic [num_out_p-1:0]             onehot_o
);

  localparam int lg_lp = safe_clog2(num_out_p);

  generate
    for (genvar gi = 0; gi < num_out_p; gi++) begin : g_dec
      assign onehot_o[gi] = v_i & (sel_i == lg_lp'(gi));
    end
  endgenerate

endmodule

// File: rtl/bsg_axil_txs.sv
// AXI-Lite write slave that pushes TDR writes into per-slot FIFOs or forwards
// control-register writes. Define BSG_AXIL_TXS_WSTRB_CHECK_EN to reject partial strobes.
module bsg_axil_txs
  import bsg_axil_to_mcl_pkg::*;
#(
  // Callers are expected to set this explicitly for their slot count
  parameter int num_fifos_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [31:0]                 awaddr_i,
  input  logic                        awvalid_i,
  output logic                        awready_o,

  input  logic [31:0]                 wdata_i,
  input  logic [3:0]                  wstrb_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,

  output logic [1:0]                  bresp_o,
  output logic                        bvalid_o,
  input  logic                        bready_i,

  output logic [num_fifos_p-1:0][31:0] txs_o,
  output logic [num_fifos_p-1:0]      txs_v_o,
  input  logic [num_fifos_p-1:0]      txs_ready_i,

  output logic [31:0]                 wr_addr_o,
  output logic [31:0]                 wr_data_o,
  output logic                        wr_v_o
);

  localparam int slot_w_lp = axil_slot_idx_width_gp;
  localparam int sel_w_lp  = safe_clog2(num_fifos_p);
  localparam logic [slot_w_lp-1:0] slot_base_lp =
    slot_w_lp'(axil_m_slot_addr_gp >> axil_base_addr_width_gp);
  localparam logic [slot_w_lp-1:0] num_fifos_lp = slot_w_lp'(num_fifos_p);

  wr_state_e state_q, state_d;

  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          strb_q, strb_d;
  logic [sel_w_lp-1:0] slot_q, slot_d;
  wr_tgt_e             tgt_q, tgt_d;
  logic [1:0]          resp_q, resp_d;

  logic aw_hs, w_hs, push_v, push_done;
  logic [slot_w_lp-1:0]               slot;
  logic [axil_base_addr_width_gp-1:0] ofs;
  wr_tgt_e                            cls_tgt;
  logic [1:0]                         cls_resp;
  logic                               unused_strb;

  // Strobes are captured for observability; only the classifier may act on them
  assign unused_strb = ^strb_q;

  assign slot = addr_q[axil_base_addr_width_gp +: slot_w_lp] - slot_base_lp;
  assign ofs  = addr_q[axil_base_addr_width_gp-1:0];

  always_comb begin
    cls_tgt  = E_TGT_ERR;
    cls_resp = axil_resp_decerr_gp;
    if (slot < num_fifos_lp) begin
      cls_resp = axil_resp_okay_gp;
      cls_tgt  = (ofs == axil_s2mm_ofs_tdr_gp) ? E_TGT_FIFO : E_TGT_REG;
`ifdef BSG_AXIL_TXS_WSTRB_CHECK_EN
      if (wstrb_i != 4'hF) begin
        cls_tgt  = E_TGT_ERR;
        cls_resp = axil_resp_slverr_gp;
      end
`endif
    end else if (slot == num_fifos_lp) begin
      cls_resp = axil_resp_slverr_gp;
    end
  end

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    strb_d = strb_q;
    slot_d = slot_q;
    tgt_d  = tgt_q;
    resp_d = resp_q;
    if (aw_hs) begin
      addr_d = awaddr_i;
    end
    if (w_hs) begin
      data_d = wdata_i;
      strb_d = wstrb_i;
      slot_d = slot[sel_w_lp-1:0];
      tgt_d  = cls_tgt;
      resp_d = cls_resp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= E_WR_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      slot_q  <= '0;
      tgt_q   <= E_TGT_ERR;
      resp_q  <= axil_resp_okay_gp;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      slot_q  <= slot_d;
      tgt_q   <= tgt_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      E_WR_IDLE: if (aw_hs) state_d = E_WR_DATA;
      E_WR_DATA: if (w_hs)  state_d = (cls_tgt == E_TGT_ERR) ? E_WR_RESP : E_WR_PUSH;
      E_WR_PUSH: if ((tgt_q != E_TGT_FIFO) || push_done) state_d = E_WR_RESP;
      E_WR_RESP: if (bready_i) state_d = E_WR_IDLE;
      default:   state_d = E_WR_IDLE;
    endcase
  end

  // Outputs are gated by reset so nothing is offered while reset is held
  always_comb begin
    awready_o = reset_n_i & (state_q == E_WR_IDLE);
    wready_o  = reset_n_i & (state_q == E_WR_DATA);
    push_v    = reset_n_i & (state_q == E_WR_PUSH) & (tgt_q == E_TGT_FIFO);
    wr_v_o    = reset_n_i & (state_q == E_WR_PUSH) & (tgt_q == E_TGT_REG);
    bvalid_o  = reset_n_i & (state_q == E_WR_RESP);
    bresp_o   = resp_q;
  end

  bsg_decode_with_v #(
    .num_out_p(num_fifos_p)
  ) u_slot_dec (
    .sel_i   (slot_q),
    .v_i     (push_v),
    .onehot_o(txs_v_o)
  );

  assign push_done = |(txs_v_o & txs_ready_i);

  generate
    for (genvar gi = 0; gi < num_fifos_p; gi++) begin : g_txs
      assign txs_o[gi] = data_q;
    end
  endgenerate

  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: tb/tb_bsg_axil_txs.sv
// Self-checking bench for bsg_axil_txs with two FIFO slots.
module tb_bsg_axil_txs;

`ifdef BSG_AXIL_TXS_WSTRB_CHECK_EN
  localparam bit STRB_CHK = 1'b1;
`else
  localparam bit STRB_CHK = 1'b0;
`endif
  localparam int NF = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [31:0]      awaddr = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [NF-1:0][31:0] txs;
  logic [NF-1:0]    txs_v;
  logic [NF-1:0]    txs_ready = '0;
  logic [31:0]      wr_addr, wr_data;
  logic             wr_v;

  bsg_axil_txs #(.num_fifos_p(NF)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .txs_o(txs), .txs_v_o(txs_v), .txs_ready_i(txs_ready),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_v_o(wr_v)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO sink and observer: ready rises after ready_delay_g cycles of valid
  int ready_delay_g = 0;
  int v_hold = 0;
  int push_count = 0, v_cycles = 0, unstable = 0, wr_count = 0;
  logic [NF-1:0] push_v, first_v;
  logic [31:0]   push_data, first_data, wr_addr_s, wr_data_s;

  always @(negedge clk) begin
    if (|txs_v) begin
      txs_ready = (v_hold >= ready_delay_g) ? '1 : '0;
      if (v_hold == 0) begin
        first_v    = txs_v;
        first_data = txs_v[1] ? txs[1] : txs[0];
      end else if (txs_v !== first_v || (txs_v[1] ? txs[1] : txs[0]) !== first_data) begin
        unstable++;
      end
      v_hold++;
      v_cycles++;
      if (|txs_ready) begin
        push_count++;
        push_v    = txs_v;
        push_data = txs_v[1] ? txs[1] : txs[0];
      end
    end else begin
      v_hold    = 0;
      txs_ready = '0;
    end
    if (wr_v) begin
      wr_count++;
      wr_addr_s = wr_addr;
      wr_data_s = wr_data;
    end
  end

  // Reference: kind 0 = FIFO push, 1 = register write, 2 = error response
  function automatic void model(input logic [31:0] a, input logic [3:0] s,
                                output int kind, output logic [1:0] resp, output int slot);
    int sl, ofs;
    sl   = (int'((a >> 12) & 32'hF) - 2 + 16) % 16;
    ofs  = int'(a & 32'hFFF);
    slot = sl;
    if (sl < NF) begin
      if (STRB_CHK && s != 4'hF) begin kind = 2; resp = 2'b10; end
      else begin kind = (ofs == 'h10) ? 0 : 1; resp = 2'b00; end
    end else if (sl == NF) begin
      kind = 2; resp = 2'b10;
    end else begin
      kind = 2; resp = 2'b11;
    end
  endfunction

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int rdly, input int bdly,
                           input int kind, input logic [1:0] eresp, input int eslot);
    int n, k, pc0, vc0, us0, wc0, exp_lat;
    logic [1:0] got_resp;
    pc0 = push_count; vc0 = v_cycles; us0 = unstable; wc0 = wr_count;
    ready_delay_g = rdly;
    exp_lat = (kind == 0) ? 3 + rdly : (kind == 1) ? 3 : 2;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    chk("awready_timeout", 32'(k < 50), 32'd1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin awvalid = 1'b0; wdata = d; wstrb = s; wvalid = 1'b1; end
      else if (wvalid) wvalid = 1'b0;
      if (bvalid) break;
    end
    chk("bvalid_latency", 32'(n), 32'(exp_lat));
    got_resp = bresp;
    chk("bresp", 32'(bresp), 32'(eresp));
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(got_resp));
      chk("awready_busy", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_after_b", 32'(bvalid), 32'd0);
    chk("awready_after_b", 32'(awready), 32'd1);
    #1;
    chk("push_count", 32'(push_count - pc0), 32'(kind == 0));
    chk("wr_count", 32'(wr_count - wc0), 32'(kind == 1));
    if (kind == 0) begin
      chk("push_v", 32'(push_v), 32'(1 << eslot));
      chk("push_data", push_data, d);
      chk("push_v_cycles", 32'(v_cycles - vc0), 32'(rdly + 1));
      chk("push_stable", 32'(unstable - us0), 32'd0);
    end
    if (kind == 1) begin
      chk("wr_addr", wr_addr_s, a);
      chk("wr_data", wr_data_s, d);
    end
    $display("txn addr=%h data=%h strb=%h kind=%0d resp=%0d lat=%0d", a, d, s, kind, got_resp, n);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          rdly;
    int          bdly;
    int          kind;
    logic [1:0]  resp;
    int          slot;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h0000_3010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1};
    tbl[1] = '{32'h0000_2010, 32'h1234_5678, 4'hF, 5, 0, 0, 2'b00, 0};
    tbl[2] = '{32'h0000_2000, 32'h0000_0005, 4'hF, 0, 0, 1, 2'b00, 0};
    tbl[3] = '{32'h0000_4010, 32'h0000_AAAA, 4'hF, 0, 0, 2, 2'b10, 0};
    tbl[4] = '{32'h0000_5010, 32'h0000_BBBB, 4'hF, 0, 0, 2, 2'b11, 0};
    tbl[5] = '{32'h0000_2010, 32'h0BAD_F00D, 4'hF, 0, 3, 0, 2'b00, 0};
    tbl[6] = '{32'h0000_2010, 32'h3333_3333, 4'h3, 0, 0, STRB_CHK ? 2 : 0,
               STRB_CHK ? 2'b10 : 2'b00, 0};
    tbl[7] = '{32'h0000_1010, 32'h0000_7777, 4'hF, 0, 0, 2, 2'b11, 0};
    tbl[8] = '{32'hFFFF_3004, 32'h0000_9999, 4'hF, 1, 1, 1, 2'b00, 1};

    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_txs_v", 32'(txs_v), 32'd0);
    chk("rst_wr_v", 32'(wr_v), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 32'd1);

    foreach (tbl[i])
      run_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].rdly, tbl[i].bdly,
                tbl[i].kind, tbl[i].resp, tbl[i].slot);

    // A W beat offered early must wait for the AW handshake
    wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("early_w_wready", 32'(wready), 32'd0);
      chk("early_w_txs_v", 32'(txs_v), 32'd0);
    end
    run_write(32'h0000_3010, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b00, 1);

    // Reset while a push is stalled abandons the transaction
    begin
      int pc0, wc0;
      pc0 = push_count; wc0 = wr_count;
      ready_delay_g = 1000;
      @(negedge clk);
      awaddr = 32'h0000_2010; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("rstmid_push_v", 32'(txs_v), 32'h1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rstmid_txs_v", 32'(txs_v), 32'd0);
      chk("rstmid_bvalid", 32'(bvalid), 32'd0);
      chk("rstmid_awready", 32'(awready), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rstmid_awready_rel", 32'(awready), 32'd1);
      repeat (3) begin
        @(negedge clk);
        chk("rstmid_no_bvalid", 32'(bvalid), 32'd0);
      end
      chk("rstmid_push_count", 32'(push_count - pc0), 32'd0);
      chk("rstmid_wr_count", 32'(wr_count - wc0), 32'd0);
      ready_delay_g = 0;
    end

    for (int t = 0; t < 30; t++) begin
      logic [31:0] a, d, hi;
      logic [3:0]  s;
      logic [11:0] o;
      int kind, slot;
      logic [1:0] resp;
      hi = $urandom;
      o  = ($urandom_range(0, 1) == 1) ? 12'h010 : 12'($urandom_range(0, 4095));
      a  = {hi[31:16], 4'($urandom_range(0, 15)), o};
      d  = $urandom;
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      model(a, s, kind, resp, slot);
      run_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 2), kind, resp, slot);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
